// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, baud-select codes and generator divisors for the UART TX scheduler
package uart_pkg;
  typedef enum logic [1:0] {IDLE, CFG, START, WAIT} state_e;
  localparam logic [1:0] BAUD_2400    = 2'b00;
  localparam logic [1:0] BAUD_4800    = 2'b01;
  localparam logic [1:0] BAUD_9600    = 2'b10;
  localparam logic [1:0] BAUD_38400   = 2'b11;
  localparam logic [1:0] BAUD_DEFAULT = BAUD_9600;
  localparam int unsigned BAUD_DIV [4] = '{240, 120, 60, 15};
  function automatic int unsigned baud_div(input logic [1:0] sel);
    return BAUD_DIV[sel];
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick of the first set request at or above ptr_i
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
    grant_o = (|req_i) ? (N'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter and its baud generator
// between NUM_REQ byte requesters, with baud reprogramming and a completion watchdog.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_baud,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 err,
  output logic [1:0]           baud_sel,
  output logic                 baud_rst_n,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  state_e               state_q;
  logic [IW-1:0]        rr_ptr_q, owner_q, arb_idx;
  logic [NUM_REQ-1:0]   arb_gnt, gnt_q, done_q;
  logic [3:0]           settle_q;
  logic [WW-1:0]        wd_q;
  logic [7:0]           tx_data_q;
  logic [1:0]           baud_sel_q;
  logic                 err_q, tx_start_q, baud_rst_n_q;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      settle_q     <= '0;
      wd_q         <= '0;
      gnt_q        <= '0;
      done_q       <= '0;
      err_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      baud_sel_q   <= BAUD_DEFAULT;
      baud_rst_n_q <= 1'b0;
    end else begin
      gnt_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_rst_n_q <= 1'b1;
          if (|req) begin
            gnt_q     <= arb_gnt;
            tx_data_q <= req_data[8*arb_idx +: 8];
            owner_q   <= arb_idx;
            rr_ptr_q  <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            // A new baud rate needs the generator held in reset while it settles.
            if (req_baud[2*arb_idx +: 2] != baud_sel_q) begin
              baud_sel_q   <= req_baud[2*arb_idx +: 2];
              baud_rst_n_q <= 1'b0;
              settle_q     <= 4'(SETTLE_CYC - 1);
              state_q      <= CFG;
            end else begin
              state_q <= START;
            end
          end
        end
        CFG: begin
          if (settle_q == '0) begin
            baud_rst_n_q <= 1'b1;
            state_q      <= START;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        START: begin
          tx_start_q <= 1'b1;
          wd_q       <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (tx_done) begin
            done_q  <= NUM_REQ'(1) << owner_q;
            state_q <= IDLE;
          end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
            err_q        <= 1'b1;
            baud_rst_n_q <= 1'b0;
            state_q      <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign baud_sel   = baud_sel_q;
  assign baud_rst_n = baud_rst_n_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed scenario tests for the round-robin UART TX scheduler
module tb_uart_tx_scheduler;
  localparam int N  = 4;
  localparam int SC = 4;
  localparam int TO = 20;
  logic         clk, rst, tx_done, err, baud_rst_n, tx_start, busy;
  logic [N-1:0] req, gnt, done;
  logic [8*N-1:0] req_data;
  logic [2*N-1:0] req_baud;
  logic [1:0]   baud_sel;
  logic [7:0]   tx_data;
  int passed = 0;
  int total  = 0;
  uart_tx_scheduler #(.NUM_REQ(N), .SETTLE_CYC(SC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_baud(req_baud),
    .gnt(gnt), .done(done), .err(err), .baud_sel(baud_sel), .baud_rst_n(baud_rst_n),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_gnt(output logic [N-1:0] g);
    int n = 0;
    while (gnt == '0 && n < 40) begin tick(); n++; end
    g = gnt;
  endtask
  task automatic wait_start();
    int n = 0;
    while (!tx_start && n < 40) begin tick(); n++; end
  endtask
  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask
  task automatic test_reset();
    tick(); tick();
    total++; if (gnt !== 4'b0 || done !== 4'b0 || err !== 1'b0) $display("FAIL reset_pulses got gnt=%b done=%b err=%b want 0", gnt, done, err); else passed++;
    total++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) $display("FAIL reset_tx got start=%b data=%h busy=%b want 0", tx_start, tx_data, busy); else passed++;
    total++; if (baud_sel !== 2'b10 || baud_rst_n !== 1'b0) $display("FAIL reset_baud got sel=%b rst_n=%b want 10/0", baud_sel, baud_rst_n); else passed++;
    rst = 1'b0;
    tick();
    total++; if (baud_rst_n !== 1'b1) $display("FAIL reset_release got rst_n=%b want 1", baud_rst_n); else passed++;
  endtask
  task automatic test_basic();
    req_data[15:8] = 8'hA5;
    req_baud[3:2]  = 2'b10;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    total++; if (gnt !== 4'b0010 || tx_data !== 8'hA5) $display("FAIL basic_gnt got gnt=%b data=%h want 0010/a5", gnt, tx_data); else passed++;
    total++; if (tx_start !== 1'b0 || busy !== 1'b1 || baud_rst_n !== 1'b1) $display("FAIL basic_gnt_cycle got start=%b busy=%b rst_n=%b want 0/1/1", tx_start, busy, baud_rst_n); else passed++;
    tick();
    total++; if (tx_start !== 1'b1 || gnt !== 4'b0 || baud_rst_n !== 1'b1) $display("FAIL basic_start got start=%b gnt=%b rst_n=%b want 1/0000/1", tx_start, gnt, baud_rst_n); else passed++;
    tick();
    total++; if (tx_start !== 1'b0 || tx_data !== 8'hA5) $display("FAIL basic_start_width got start=%b data=%h want 0/a5", tx_start, tx_data); else passed++;
    pulse_done();
    total++; if (done !== 4'b0010 || busy !== 1'b0 || err !== 1'b0) $display("FAIL basic_done got done=%b busy=%b err=%b want 0010/0/0", done, busy, err); else passed++;
    tick();
    total++; if (done !== 4'b0) $display("FAIL basic_done_width got %b want 0000", done); else passed++;
  endtask
  task automatic test_cfg();
    int n;
    req_data[7:0] = 8'h3C;
    req_baud[1:0] = 2'b00;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    total++; if (gnt !== 4'b0001 || baud_sel !== 2'b00 || baud_rst_n !== 1'b0) $display("FAIL cfg_gnt got gnt=%b sel=%b rst_n=%b want 0001/00/0", gnt, baud_sel, baud_rst_n); else passed++;
    n = 1;
    while (!baud_rst_n && n < 30) begin tick(); if (!baud_rst_n) n++; end
    total++; if (n !== SC || tx_start !== 1'b0) $display("FAIL cfg_settle got low=%0d start=%b want %0d/0", n, tx_start, SC); else passed++;
    tick();
    total++; if (tx_start !== 1'b1 || baud_rst_n !== 1'b1) $display("FAIL cfg_start got start=%b rst_n=%b want 1/1", tx_start, baud_rst_n); else passed++;
    pulse_done();
    total++; if (done !== 4'b0001) $display("FAIL cfg_done got %b want 0001", done); else passed++;
  endtask
  task automatic test_rst_mid();
    logic [N-1:0] g;
    req_data[23:16] = 8'h77;
    req_baud[5:4]   = 2'b01;
    req = 4'b0100;
    wait_gnt(g);
    req = 4'b0000;
    wait_start();
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || tx_data !== 8'h00 || tx_start !== 1'b0 || gnt !== 4'b0) $display("FAIL rst_mid_tx got busy=%b data=%h start=%b gnt=%b want 0", busy, tx_data, tx_start, gnt); else passed++;
    total++; if (baud_sel !== 2'b10 || baud_rst_n !== 1'b0) $display("FAIL rst_mid_baud got sel=%b rst_n=%b want 10/0", baud_sel, baud_rst_n); else passed++;
    tick();
    rst = 1'b0;
    tick();
    pulse_done();
    total++; if (done !== 4'b0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_stray_done got done=%b err=%b busy=%b want 0", done, err, busy); else passed++;
  endtask
  task automatic test_fairness();
    logic [N-1:0] g;
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = 8'(8'h11 * (i + 1));
      req_baud[2*i +: 2] = 2'b10;
    end
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(g);
      total++; if (g !== 4'(1 << exp_idx[t]) || tx_data !== 8'(8'h11 * (exp_idx[t] + 1))) $display("FAIL fair_gnt%0d got gnt=%b data=%h want idx %0d", t, g, tx_data, exp_idx[t]); else passed++;
      wait_start();
      repeat (10) tick();
      pulse_done();
      total++; if (done !== g) $display("FAIL fair_done%0d got %b want %b", t, done, g); else passed++;
    end
    req = 4'b0000;
    tick();
  endtask
  task automatic test_timeout();
    logic [N-1:0] g;
    logic [N-1:0] seen_done = '0;
    int n = 0;
    req_data[31:24] = 8'h5A;
    req = 4'b1000;
    wait_gnt(g);
    req = 4'b0000;
    wait_start();
    do begin tick(); n++; seen_done |= done; end while (!err && n < 100);
    total++; if (n !== TO || seen_done !== 4'b0) $display("FAIL timeout_err got cycles=%0d done=%b want %0d/0000", n, seen_done, TO); else passed++;
    total++; if (baud_rst_n !== 1'b0 || busy !== 1'b0) $display("FAIL timeout_abort got rst_n=%b busy=%b want 0/0", baud_rst_n, busy); else passed++;
    tick();
    total++; if (baud_rst_n !== 1'b1 || err !== 1'b0 || done !== 4'b0) $display("FAIL timeout_after got rst_n=%b err=%b done=%b want 1/0/0000", baud_rst_n, err, done); else passed++;
    req = 4'b0010;
    wait_gnt(g);
    req = 4'b0000;
    wait_start();
    repeat (3) tick();
    pulse_done();
    total++; if (g !== 4'b0010 || done !== 4'b0010 || err !== 1'b0) $display("FAIL timeout_recover got gnt=%b done=%b err=%b want 0010/0010/0", g, done, err); else passed++;
  endtask
  task automatic test_tie();
    logic [N-1:0] g;
    req = 4'b0100;
    wait_gnt(g);
    req = 4'b0000;
    wait_start();
    repeat (TO - 1) tick();
    pulse_done();
    total++; if (done !== 4'b0100 || err !== 1'b0) $display("FAIL tie_done got done=%b err=%b want 0100/0", done, err); else passed++;
    tick();
    total++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL tie_after got err=%b busy=%b want 0/0", err, busy); else passed++;
  endtask
  initial begin
    rst = 1'b1; req = '0; req_data = '0; req_baud = '0; tx_done = 1'b0;
    test_reset();
    test_basic();
    test_cfg();
    test_rst_mid();
    test_fairness();
    test_timeout();
    test_tie();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter and its baud rate generator between NUM_REQ byte-level requesters, using round-robin arbitration.
- For each granted request, programs the generator's baud_sel and holds the generator in reset while the selection changes.
- Then issues a one-cycle start to the transmitter and waits for completion or a watchdog timeout.
- Sits between client logic and the transmitter/baud generator pair.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE_CYC, 4, cycles the generator is held in reset after a baud_sel change (1..15).
- TIMEOUT_CYC, 2000000, maximum cycles waiting for tx_done before abort; counter width = $clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  system clock (18.432 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request per requester; held until its gnt pulse
- req_data  in  8*NUM_REQ  byte per requester; slice i = bits [8i+7:8i]
- req_baud  in  2*NUM_REQ  baud select per requester (00=2400, 01=4800, 10=9600, 11=38400)
- gnt  out  NUM_REQ  one-hot, 1-cycle pulse when a request is captured
- done  out  NUM_REQ  one-hot, 1-cycle pulse when that requester's byte finishes
- err  out  1  1-cycle pulse on watchdog abort
- baud_sel  out  2  to baud generator
- baud_rst_n  out  1  active-low reset to baud generator
- tx_data  out  8  byte to transmitter, stable from START until WAIT exits
- tx_start  out  1  1-cycle start pulse to transmitter
- tx_done  in  1  1-cycle pulse from transmitter at end of stop bit
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: gnt=0, done=0, err=0, tx_start=0, tx_data=0, busy=0, baud_sel=2'b10, baud_rst_n=0, rr_ptr=0, state=IDLE.
- baud_rst_n goes 1 on the first clk after rst deasserts (generator runs at 9600 by default).
- FSM states: IDLE, CFG, START, WAIT.
- IDLE:
  - If any req is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - In the same cycle, pulse gnt[i], latch req_data slice into tx_data, latch owner index i.
  - Set rr_ptr = (i+1) mod NUM_REQ.
  - If req_baud[i] != baud_sel: load baud_sel, drive baud_rst_n=0, load settle counter with SETTLE_CYC-1, go to CFG.
  - Otherwise go to START.
- CFG:
  - baud_rst_n held 0; decrement the settle counter.
  - At 0: baud_rst_n=1, go to START.
  - Generator reset low time = exactly SETTLE_CYC cycles.
- START: tx_start=1 for exactly one cycle; clear the watchdog; go to WAIT.
- WAIT:
  - On tx_done: done[owner] pulses next cycle, go to IDLE.
  - Watchdog counts each cycle. At TIMEOUT_CYC-1 without tx_done: err pulses, baud_rst_n=0 for one cycle, go to IDLE. No done pulse on abort.
- Latency (baud unchanged, idle): req rises cycle 0 -> gnt at cycle 0 edge -> tx_start high in cycle 1.
- Latency (baud changed): tx_start high in cycle 1+SETTLE_CYC.
- Minimum gap from done to the next gnt is 1 cycle; back-to-back requests never overlap.
- tx_done outside WAIT is ignored.
- tx_done in the same cycle the watchdog expires: tx_done wins; done pulses, no err.
- req dropped after gnt does not cancel the transfer.
- req inputs are sampled only in IDLE.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 transfers.
- rst mid-operation: all outputs return immediately to reset values and the in-flight byte is dropped (no done, no err). baud_sel reverts to 10.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, CFG, START, WAIT);
  - baud-select constants BAUD_2400..BAUD_38400;
  - default BAUD_9600;
  - divisor table (240/120/60/15).
- One natural sub-module, rr_arbiter: inputs req, ptr; outputs one-hot grant and index. Purely combinational priority-rotate.

Test Plan:
- Reset release, req=4'b0010, req_baud[1]=10, data 8'hA5 -> gnt=0010 and tx_data=A5; tx_start exactly 1 cycle later; baud_rst_n never low; tx_done pulse -> done=0010 next cycle.
- req=4'b0001 with req_baud[0]=00, SETTLE_CYC=4 -> baud_sel=00 at gnt; baud_rst_n low exactly 4 cycles; tx_start the cycle after it rises.
- req=4'b1111 held, tx_done driven 10 cycles after each tx_start -> grant order 0,1,2,3,0; each done matches the preceding gnt index.
- Timeout test (TIMEOUT_CYC=50), no tx_done -> err pulse 50 cycles after tx_start; baud_rst_n low 1 cycle; no done; next req served normally.
- rst asserted 3 cycles into WAIT -> all outputs at reset values in the same cycle; baud_sel=10; the later tx_done is ignored; rr_ptr=0.
- tx_done and watchdog expiry in the same cycle (TIMEOUT_CYC=20, tx_done at cycle 19 of WAIT) -> done pulses; err stays 0.
